// File: rtl/spi_slave_if.sv
// Fabric-side handshake bundle of the SPI target: TX holding-register write
// port and RX character delivery.
interface spi_slave_if #(
    parameter int unsigned DW = 8
);
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          tx_underrun;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun
    );
endinterface

// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples SCK/CS/MOSI in the clk domain, all four
// CPOL/CPHA modes, MSB/LSB first, back-to-back characters within one CS.
module spi_slave #(
    parameter int unsigned DW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       rev,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       busy,
    spi_slave_if.slave bus
);
    localparam int unsigned   CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state;
    logic [2:0]    sck_sy, cs_sy;
    logic [1:0]    mosi_sy;
    logic          sck_edge, sck_lvl;
    logic          cpol_l, cpha_l, rev_l;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rx_sr, tx_sr, hold;
    logic          load_empty;

    logic          cs_fall, cs_rise, leading, trailing, sample_e, shift_e;
    logic [DW-1:0] rx_next, tx_shift, load_val;

    // Two-stage synchronizers plus history stage; SCK edge is registered once more.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sy   <= '0;
            cs_sy    <= '0;
            mosi_sy  <= '0;
            sck_edge <= 1'b0;
            sck_lvl  <= 1'b0;
        end else begin
            sck_sy   <= {sck_sy[1:0], spi_sck};
            cs_sy    <= {cs_sy[1:0], spi_cs_n};
            mosi_sy  <= {mosi_sy[0], spi_mosi};
            sck_edge <= sck_sy[1] ^ sck_sy[2];
            sck_lvl  <= sck_sy[1];
        end
    end

    always_comb begin
        cs_fall  = cs_sy[2] & ~cs_sy[1];
        cs_rise  = ~cs_sy[2] & cs_sy[1];
        leading  = sck_edge & (sck_lvl != cpol_l);
        trailing = sck_edge & (sck_lvl == cpol_l);
        sample_e = cpha_l ? trailing : leading;
        shift_e  = cpha_l ? leading : trailing;
        rx_next  = rev_l ? {rx_sr[DW-2:0], mosi_sy[1]} : {mosi_sy[1], rx_sr[DW-1:1]};
        tx_shift = rev_l ? {tx_sr[DW-2:0], 1'b0} : {1'b0, tx_sr[DW-1:1]};
        load_val = bus.tx_ready ? '0 : hold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cpol_l          <= 1'b0;
            cpha_l          <= 1'b0;
            rev_l           <= 1'b0;
            cnt             <= '0;
            rx_sr           <= '0;
            tx_sr           <= '0;
            hold            <= '0;
            load_empty      <= 1'b1;
            spi_miso        <= 1'b0;
            spi_miso_oe     <= 1'b0;
            busy            <= 1'b0;
            bus.tx_ready    <= 1'b1;
            bus.rx_data     <= '0;
            bus.rx_valid    <= 1'b0;
            bus.tx_underrun <= 1'b0;
        end else begin
            bus.rx_valid    <= 1'b0;
            bus.tx_underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall && en) begin
                        state       <= ACTIVE;
                        cpol_l      <= cpol;
                        cpha_l      <= cpha;
                        rev_l       <= rev;
                        cnt         <= '0;
                        rx_sr       <= '0;
                        spi_miso_oe <= 1'b1;
                        busy        <= 1'b1;
                        // In CPHA=0 the first bit must be on MISO before the first edge.
                        if (!cpha) begin
                            tx_sr      <= load_val;
                            spi_miso   <= rev ? load_val[DW-1] : load_val[0];
                            load_empty <= bus.tx_ready;
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_rise || !en) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        rx_sr       <= '0;
                        spi_miso_oe <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        if (sample_e) begin
                            rx_sr <= rx_next;
                            if (cnt == LAST) begin
                                bus.rx_data  <= rx_next;
                                bus.rx_valid <= 1'b1;
                                cnt          <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                            if (cnt == '0) begin
                                bus.tx_ready    <= 1'b1;
                                bus.tx_underrun <= load_empty;
                            end
                        end
                        if (shift_e) begin
                            if (cnt == '0) begin
                                tx_sr      <= load_val;
                                spi_miso   <= rev_l ? load_val[DW-1] : load_val[0];
                                load_empty <= bus.tx_ready;
                            end else begin
                                tx_sr    <= tx_shift;
                                spi_miso <= rev_l ? tx_shift[DW-1] : tx_shift[0];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A write in the same cycle as a consumption wins.
            if (bus.tx_valid && bus.tx_ready) begin
                hold         <= bus.tx_data;
                bus.tx_ready <= 1'b0;
            end
        end
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI target (slave) endpoint for the other end of the eSPI-compatible SPI master: it answers a master's SCK/CS/MOSI with MISO data and delivers received characters to the local fabric. All SPI pins are oversampled in the single system clock domain; no SCK-clocked logic exists. It supports all four CPOL/CPHA modes, MSB- or LSB-first order (eSPI REV), and back-to-back characters within one chip-select.

## Interface
- `DW`, 8: character length in bits; legal range 4..16.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  block enable; 0 = ignore bus, MISO tri-stated.
- `cpol`  in  1  SCK idle level; latched at CS assertion.
- `cpha`  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at CS assertion.
- `rev`  in  1  1 = MSB first, 0 = LSB first; latched at CS assertion.
- `spi_sck`  in  1  SPI clock from master (asynchronous).
- `spi_cs_n`  in  1  chip select, active low (asynchronous).
- `spi_mosi`  in  1  master-out data (asynchronous).
- `spi_miso`  out  1  slave-out data.
- `spi_miso_oe`  out  1  MISO output enable, active high.
- `tx_data`  in  DW  next character to transmit.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  holding register empty; write occurs when `tx_valid & tx_ready`.
- `rx_data`  out  DW  last received character; held until the next one.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` updated.
- `tx_underrun`  out  1  one-cycle pulse, character started with empty holding register.
- `busy`  out  1  synchronized CS asserted and `en` = 1.

## Operation
- Input sync: 2-FF synchronizer on `spi_sck`, `spi_cs_n`, `spi_mosi`, plus one history stage for edge detection on SCK and CS.
- Leading edge = SCK transition away from `cpol`; trailing edge = transition back. Sample edge = leading if `cpha`=0, trailing if `cpha`=1; the other edge is the shift edge.
- States: IDLE (CS high or `en`=0), ACTIVE (CS low and `en`=1). IDLE→ACTIVE on synchronized CS fall with `en`=1: latch `cpol/cpha/rev`, clear bit counter `cnt`. ACTIVE→IDLE on CS rise or `en` falling.
- RX: on each sample edge, shift synchronized MOSI into rx shift register per `rev`; `cnt` increments. When `cnt`=DW-1 at a sample edge: `rx_data` ← completed character, `rx_valid` pulse, `cnt` ← 0. There is no back-pressure; an unread character is overwritten.
- TX: one holding register plus tx shift register; `spi_miso` = shift-register MSB (`rev`=1) or LSB (`rev`=0).
- Load points: shift edge with `cnt`=0, and, when `cpha`=0, CS assertion. A load copies the holding register (all-zero if empty) without consuming it; other shift edges shift by one.
- Consumption: at the first sample edge of each character, the holding register is marked empty (`tx_ready` → 1). If it was empty at the preceding load, `tx_underrun` pulses and zeros are shifted out.
- CS rise mid-character: partial RX discarded (no `rx_valid`), `cnt` ← 0; a holding register already consumed is lost; an unconsumed one (no sample edge yet) remains.
- `spi_miso_oe` = ACTIVE state.
- `tx_valid` is accepted in any state; a write and a consumption in the same cycle: the write wins and `tx_ready` stays 0.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `busy`=0; shift registers, `cnt`, and holding register cleared; state IDLE.
- SCK pin edge → internal edge detect: 3 clk. `rx_valid` asserts 4 clk after the final sample edge on the pin. `spi_miso` updates 4 clk after a shift edge on the pin (3 clk when the load point is CS assertion).
- SCK requirement: each SCK half-period ≥ 4 clk (f_sck ≤ f_clk/8). CS-fall to first SCK edge ≥ 4 clk.
- `rst` mid-frame: immediate return to reset values; the bus is ignored until the synchronized CS is seen high, then low again.

## Test plan
- Mode 0, `rev`=1, `DW`=8: preload 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C with a single `rx_valid` pulse; `tx_ready` rises at the first sample edge.
- Modes 1/2/3, `rev`=0: preload 0x81, master sends 0x0F -> master reads 0x81 and `rx_data`=0x0F in every mode.
- Three back-to-back characters in one CS, mode 0: write 0x11, 0x22, 0x33 as `tx_ready` rises -> master reads 0x11 0x22 0x33; 3 `rx_valid` pulses; no underrun.
- Empty holding register, mode 1 -> MISO shifts 0x00 and `tx_underrun` pulses once at the first sample edge.
- CS deasserts after 5 bits -> no `rx_valid`, `cnt`=0; the next full frame receives correctly. Repeat with a `rst` pulse mid-frame -> all outputs return to reset values.
- `en`=0 during a full master frame -> `spi_miso_oe`=0, `busy`=0, no `rx_valid`, holding register untouched.
